// File: rtl/video_pkg.sv
// Shared types and address constants for the video bus arbiter slice:
// PPU mode encoding, DMA FSM states, read-return source tags and the
// echo-remap helper used when the DMA source page is latched.
package video_pkg;

    typedef enum logic [1:0] {
        H_BLANK = 2'd0,
        V_BLANK = 2'd1,
        SCAN    = 2'd2,
        DRAW    = 2'd3
    } ppu_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } dma_state_t;

    // Which RAM a requester's read was issued to; selects rdata next cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_VRAM = 2'd1,
        SRC_OAM  = 2'd2
    } rd_src_t;

    localparam logic [15:0] VRAM_BASE  = 16'h8000;
    localparam logic [15:0] VRAM_END   = 16'h9FFF;
    localparam logic [15:0] OAM_BASE   = 16'hFE00;
    localparam logic [15:0] OAM_END    = 16'hFE9F;
    localparam logic [15:0] DMA_REG    = 16'hFF46;
    localparam logic [7:0]  ECHO_LIMIT = 8'hDF;

    // Pages above DF are echo RAM; fold them back onto C0-DF.
    function automatic logic [7:0] dma_src_page(input logic [7:0] wdata);
        return (wdata > ECHO_LIMIT) ? (wdata - 8'h20) : wdata;
    endfunction

endpackage

// File: rtl/video_bus_arbiter_if.sv
// Bundle of CPU, PPU, VRAM, OAM and DMA-source signals around the arbiter.
// master = the arbiter, slave = everything around it.
// Strobe semantics: every *_rd / *_wr is a single-cycle request with no
// back-pressure; read data returns on the cycle after the strobe.
interface video_bus_arbiter_if #(
    parameter int VRAM_AW = 13
);
    import video_pkg::*;

    logic [15:0]        cpu_addr;
    logic               cpu_rd;
    logic               cpu_wr;
    logic [7:0]         cpu_wdata;
    logic [7:0]         cpu_rdata;
    logic               cpu_dma_blocked;

    ppu_mode_t          ppu_mode;
    logic               ppu_rd;
    logic [15:0]        ppu_addr;
    logic [7:0]         ppu_rdata;

    logic [VRAM_AW-1:0] vram_addr;
    logic               vram_rd;
    logic               vram_wr;
    logic [7:0]         vram_wdata;
    logic [7:0]         vram_rdata;

    logic [7:0]         oam_addr;
    logic               oam_rd;
    logic               oam_wr;
    logic [7:0]         oam_wdata;
    logic [7:0]         oam_rdata;

    logic [15:0]        dma_src_addr;
    logic               dma_src_rd;
    logic [7:0]         dma_src_rdata;
    logic               dma_active;
    dma_state_t         dma_state;

    modport master (
        input  cpu_addr, cpu_rd, cpu_wr, cpu_wdata, ppu_mode, ppu_rd, ppu_addr,
               vram_rdata, oam_rdata, dma_src_rdata,
        output cpu_rdata, cpu_dma_blocked, ppu_rdata, vram_addr, vram_rd, vram_wr,
               vram_wdata, oam_addr, oam_rd, oam_wr, oam_wdata, dma_src_addr,
               dma_src_rd, dma_active, dma_state
    );

    modport slave (
        output cpu_addr, cpu_rd, cpu_wr, cpu_wdata, ppu_mode, ppu_rd, ppu_addr,
               vram_rdata, oam_rdata, dma_src_rdata,
        input  cpu_rdata, cpu_dma_blocked, ppu_rdata, vram_addr, vram_rd, vram_wr,
               vram_wdata, oam_addr, oam_rd, oam_wr, oam_wdata, dma_src_addr,
               dma_src_rd, dma_active, dma_state
    );

endinterface

// File: rtl/video_bus_arbiter_oam_dma_engine.sv
// OAM DMA engine: copies OAM_BYTES bytes from page src_hi into OAM.
// Sequence is START (one idle cycle) then READ/WRITE pairs per byte.
// All outputs are registered; a new start restarts from idx 0 in any state.
module oam_dma_engine
    import video_pkg::*;
#(
    parameter int OAM_BYTES = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  start_data,
    output logic        active,
    output logic [15:0] src_addr,
    output logic        src_rd,
    output logic        oam_wr,
    output logic [7:0]  oam_addr,
    output dma_state_t  state
);
    localparam logic [7:0] LAST_IDX = 8'(OAM_BYTES - 1);

    dma_state_t  state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  src_hi_q, src_hi_d;
    logic        active_q, active_d;
    logic [15:0] src_addr_q, src_addr_d;
    logic        src_rd_q, src_rd_d;
    logic        oam_wr_q, oam_wr_d;
    logic [7:0]  oam_addr_q, oam_addr_d;

    // Next state and next registered outputs; strobes are one-cycle pulses.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        src_hi_d   = src_hi_q;
        active_d   = active_q;
        src_addr_d = src_addr_q;
        oam_addr_d = oam_addr_q;
        src_rd_d   = 1'b0;
        oam_wr_d   = 1'b0;
        if (start) begin
            state_d  = START;
            idx_d    = 8'd0;
            src_hi_d = dma_src_page(start_data);
            active_d = 1'b1;
        end else begin
            case (state_q)
                START: begin
                    state_d    = READ;
                    src_rd_d   = 1'b1;
                    src_addr_d = {src_hi_q, idx_q};
                end
                READ: begin
                    state_d    = WRITE;
                    oam_wr_d   = 1'b1;
                    oam_addr_d = idx_q;
                end
                WRITE: begin
                    if (idx_q == LAST_IDX) begin
                        state_d  = IDLE;
                        active_d = 1'b0;
                    end else begin
                        idx_d      = idx_q + 8'd1;
                        state_d    = READ;
                        src_rd_d   = 1'b1;
                        src_addr_d = {src_hi_q, idx_d};
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM and output registers; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 8'd0;
            src_hi_q   <= 8'd0;
            active_q   <= 1'b0;
            src_addr_q <= 16'd0;
            src_rd_q   <= 1'b0;
            oam_wr_q   <= 1'b0;
            oam_addr_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            src_hi_q   <= src_hi_d;
            active_q   <= active_d;
            src_addr_q <= src_addr_d;
            src_rd_q   <= src_rd_d;
            oam_wr_q   <= oam_wr_d;
            oam_addr_q <= oam_addr_d;
        end
    end

    assign active   = active_q;
    assign src_addr = src_addr_q;
    assign src_rd   = src_rd_q;
    assign oam_wr   = oam_wr_q;
    assign oam_addr = oam_addr_q;
    assign state    = state_q;

endmodule

// File: rtl/video_bus_arbiter.sv
// Video bus arbiter: shares VRAM and OAM between CPU, PPU and OAM DMA.
// OAM priority is DMA > PPU > CPU; VRAM priority is PPU > CPU.
// Optional macro VIDEO_MODE_LOCK_EN adds PPU-mode based CPU lockout
// (no VRAM in DRAW, no OAM in SCAN/DRAW); without it the CPU only loses
// to a same-cycle PPU request or to DMA.
module video_bus_arbiter
    import video_pkg::*;
#(
    parameter int OAM_BYTES = 160,
    parameter int VRAM_AW   = 13
) (
    input logic                 clk,
    input logic                 rst,
    video_bus_arbiter_if.master bus
);
    logic        dma_start;
    logic        dma_active;
    logic [15:0] dma_src_addr;
    logic        dma_src_rd;
    logic        dma_oam_wr;
    logic [7:0]  dma_oam_addr;
    dma_state_t  dma_state;

    logic cpu_req, cpu_in_vram, cpu_in_oam;
    logic ppu_in_vram, ppu_in_oam;
    logic ppu_vram_gnt, ppu_oam_gnt;
    logic cpu_vram_ok, cpu_oam_ok;
    logic cpu_vram_gnt, cpu_oam_gnt;

    rd_src_t cpu_tag_q, cpu_tag_d;
    rd_src_t ppu_tag_q, ppu_tag_d;

    assign dma_start = bus.cpu_wr && (bus.cpu_addr == DMA_REG);

    oam_dma_engine #(.OAM_BYTES(OAM_BYTES)) u_dma (
        .clk        (clk),
        .rst        (rst),
        .start      (dma_start),
        .start_data (bus.cpu_wdata),
        .active     (dma_active),
        .src_addr   (dma_src_addr),
        .src_rd     (dma_src_rd),
        .oam_wr     (dma_oam_wr),
        .oam_addr   (dma_oam_addr),
        .state      (dma_state)
    );

    assign cpu_req     = !rst && (bus.cpu_rd || bus.cpu_wr);
    assign cpu_in_vram = (bus.cpu_addr >= VRAM_BASE) && (bus.cpu_addr <= VRAM_END);
    assign cpu_in_oam  = (bus.cpu_addr >= OAM_BASE) && (bus.cpu_addr <= OAM_END);
    assign ppu_in_vram = (bus.ppu_addr >= VRAM_BASE) && (bus.ppu_addr <= VRAM_END);
    assign ppu_in_oam  = (bus.ppu_addr >= OAM_BASE) && (bus.ppu_addr <= OAM_END);

    // PPU always wins its RAM, except OAM which belongs to DMA while active.
    assign ppu_vram_gnt = !rst && bus.ppu_rd && ppu_in_vram;
    assign ppu_oam_gnt  = !rst && bus.ppu_rd && ppu_in_oam && !dma_active;

`ifdef VIDEO_MODE_LOCK_EN
    assign cpu_vram_ok = (bus.ppu_mode != DRAW);
    assign cpu_oam_ok  = (bus.ppu_mode == H_BLANK) || (bus.ppu_mode == V_BLANK);
`else
    assign cpu_vram_ok = 1'b1;
    assign cpu_oam_ok  = 1'b1;
`endif

    assign cpu_vram_gnt = cpu_req && cpu_in_vram && cpu_vram_ok && !ppu_vram_gnt;
    assign cpu_oam_gnt  = cpu_req && cpu_in_oam && cpu_oam_ok && !dma_active
                          && !ppu_oam_gnt;

    // VRAM port mux: PPU first, then CPU.
    always_comb begin
        bus.vram_addr  = '0;
        bus.vram_rd    = 1'b0;
        bus.vram_wr    = 1'b0;
        bus.vram_wdata = 8'h00;
        if (ppu_vram_gnt) begin
            bus.vram_addr = VRAM_AW'(bus.ppu_addr - VRAM_BASE);
            bus.vram_rd   = 1'b1;
        end else if (cpu_vram_gnt) begin
            bus.vram_addr  = VRAM_AW'(bus.cpu_addr - VRAM_BASE);
            bus.vram_rd    = bus.cpu_rd;
            bus.vram_wr    = bus.cpu_wr;
            bus.vram_wdata = bus.cpu_wdata;
        end
    end

    // OAM port mux: DMA write, then PPU read, then CPU.
    always_comb begin
        bus.oam_addr  = 8'h00;
        bus.oam_rd    = 1'b0;
        bus.oam_wr    = 1'b0;
        bus.oam_wdata = 8'h00;
        if (dma_oam_wr) begin
            bus.oam_addr  = dma_oam_addr;
            bus.oam_wr    = 1'b1;
            bus.oam_wdata = bus.dma_src_rdata;
        end else if (ppu_oam_gnt) begin
            bus.oam_addr = bus.ppu_addr[7:0];
            bus.oam_rd   = 1'b1;
        end else if (cpu_oam_gnt) begin
            bus.oam_addr  = bus.cpu_addr[7:0];
            bus.oam_rd    = bus.cpu_rd;
            bus.oam_wr    = bus.cpu_wr;
            bus.oam_wdata = bus.cpu_wdata;
        end
    end

    // Tag each granted read with the RAM it went to.
    always_comb begin
        cpu_tag_d = SRC_NONE;
        ppu_tag_d = SRC_NONE;
        if (bus.cpu_rd && cpu_vram_gnt)     cpu_tag_d = SRC_VRAM;
        else if (bus.cpu_rd && cpu_oam_gnt) cpu_tag_d = SRC_OAM;
        if (ppu_vram_gnt)                   ppu_tag_d = SRC_VRAM;
        else if (ppu_oam_gnt)               ppu_tag_d = SRC_OAM;
    end

    // Read-return tag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_tag_q <= SRC_NONE;
            ppu_tag_q <= SRC_NONE;
        end else begin
            cpu_tag_q <= cpu_tag_d;
            ppu_tag_q <= ppu_tag_d;
        end
    end

    // Return data; denied or unmapped reads see FF.
    always_comb begin
        bus.cpu_rdata = 8'hFF;
        bus.ppu_rdata = 8'hFF;
        case (cpu_tag_q)
            SRC_VRAM: bus.cpu_rdata = bus.vram_rdata;
            SRC_OAM:  bus.cpu_rdata = bus.oam_rdata;
            default:  bus.cpu_rdata = 8'hFF;
        endcase
        case (ppu_tag_q)
            SRC_VRAM: bus.ppu_rdata = bus.vram_rdata;
            SRC_OAM:  bus.ppu_rdata = bus.oam_rdata;
            default:  bus.ppu_rdata = 8'hFF;
        endcase
    end

    assign bus.dma_active      = dma_active;
    assign bus.cpu_dma_blocked = dma_active;
    assign bus.dma_src_addr    = dma_src_addr;
    assign bus.dma_src_rd      = dma_src_rd;
    assign bus.dma_state       = dma_state;

endmodule

// File: tb/tb_video_bus_arbiter.sv
// Bench for video_bus_arbiter: RAM/source models, scenario tasks, summary.
`timescale 1ns/1ps
module tb_video_bus_arbiter;
    import video_pkg::*;

    localparam int OAM_BYTES = 160;
    localparam int VRAM_AW   = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    video_bus_arbiter_if #(.VRAM_AW(VRAM_AW)) bus ();

    video_bus_arbiter #(.OAM_BYTES(OAM_BYTES), .VRAM_AW(VRAM_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  oam_mem [0:255];

    function automatic logic [7:0] vram_init(input logic [15:0] a);
        return a[7:0] ^ 8'h5C ^ {a[12:8], 3'b000};
    endfunction

    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return (a[15:8] == 8'hC1) ? a[7:0] : (a[7:0] ^ a[15:8]);
    endfunction

    // Synchronous RAM and DMA-source models, one cycle of read latency.
    always @(posedge clk) begin
        if (bus.vram_rd)    bus.vram_rdata <= vram_init(16'(bus.vram_addr));
        if (bus.oam_rd)     bus.oam_rdata <= oam_mem[bus.oam_addr];
        if (bus.oam_wr)     oam_mem[bus.oam_addr] <= bus.oam_wdata;
        if (bus.dma_src_rd) bus.dma_src_rdata <= src_byte(bus.dma_src_addr);
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic idle_inputs();
        bus.cpu_addr  = 16'h0000;
        bus.cpu_rd    = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.cpu_wdata = 8'h00;
        bus.ppu_rd    = 1'b0;
        bus.ppu_addr  = 16'h0000;
        bus.ppu_mode  = H_BLANK;
    endtask

    task automatic dma_write(input logic [7:0] page);
        @(negedge clk);
        bus.cpu_addr  = DMA_REG;
        bus.cpu_wr    = 1'b1;
        bus.cpu_wdata = page;
        @(negedge clk);
        bus.cpu_wr    = 1'b0;
        bus.cpu_addr  = 16'h0000;
        bus.cpu_wdata = 8'h00;
    endtask

    // Follows one DMA from the cycle after the trigger to dma_active falling.
    task automatic watch_dma(input string name, input logic [7:0] hi);
        int active_n = 0;
        int rd_n = 0;
        int bad = 0;
        bit timed_out = 1'b1;
        logic [7:0]  last_addr = 8'h00;
        logic [15:0] exp;
        exp_q.delete();
        for (int i = 0; i < OAM_BYTES; i++) exp_q.push_back({8'(i), src_byte({hi, 8'(i)})});
        for (int c = 0; c < 400; c++) begin
            #1;
            if (!bus.dma_active) begin
                timed_out = 1'b0;
                break;
            end
            active_n++;
            if (bus.dma_src_rd) begin
                n_checks++;
                if (bus.dma_src_addr !== {hi, 8'(rd_n)}) begin
                    n_fail++;
                    $display("FAIL %s_src_addr: got %h expected %h", name, bus.dma_src_addr, {hi, 8'(rd_n)});
                end
                rd_n++;
            end
            if (bus.oam_wr) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s_extra_oam_wr: got write to %h expected none", name, bus.oam_addr);
                end else begin
                    exp = exp_q.pop_front();
                    if ({bus.oam_addr, bus.oam_wdata} !== exp) begin
                        n_fail++;
                        $display("FAIL %s_oam_wr: got addr/data %h expected %h", name, {bus.oam_addr, bus.oam_wdata}, exp);
                    end
                end
                last_addr = bus.oam_addr;
            end
            @(negedge clk);
        end
        n_checks++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL %s_timeout: got dma_active still high expected low within 400 cycles", name);
        end
        n_checks++;
        if (active_n != 321) begin
            n_fail++;
            $display("FAIL %s_duration: got %0d cycles expected 321", name, active_n);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_writes: got %0d left expected 0", name, exp_q.size());
        end
        n_checks++;
        if (last_addr !== 8'h9F) begin
            n_fail++;
            $display("FAIL %s_last_idx: got %h expected 9f", name, last_addr);
        end
        for (int i = 0; i < OAM_BYTES; i++) if (oam_mem[i] !== src_byte({hi, 8'(i)})) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s_oam_contents: got %0d wrong bytes expected 0", name, bad);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = 16'h8010;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({bus.vram_rd, bus.vram_wr, bus.oam_rd, bus.oam_wr, bus.dma_src_rd} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 00000",
                     {bus.vram_rd, bus.vram_wr, bus.oam_rd, bus.oam_wr, bus.dma_src_rd});
        end
        n_checks++;
        if ({bus.vram_addr, bus.oam_addr, bus.dma_src_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_addrs: got %h %h %h expected 0", bus.vram_addr, bus.oam_addr, bus.dma_src_addr);
        end
        n_checks++;
        if ({bus.cpu_rdata, bus.ppu_rdata} !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h %h expected ff ff", bus.cpu_rdata, bus.ppu_rdata);
        end
        n_checks++;
        if ({bus.dma_active, bus.cpu_dma_blocked} !== 2'b00 || bus.dma_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_dma: got active %b blocked %b state %0d expected 0 0 IDLE",
                     bus.dma_active, bus.cpu_dma_blocked, bus.dma_state);
        end
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_dma_basic();
        dma_write(8'hC1);
        watch_dma("dma_c1", 8'hC1);
    endtask

    task automatic test_dma_retrigger();
        dma_write(8'hC1);
        repeat (48) @(negedge clk);
        #1;
        n_checks++;
        if (bus.dma_active !== 1'b1) begin
            n_fail++;
            $display("FAIL retrig_mid_active: got %b expected 1", bus.dma_active);
        end
        dma_write(8'hD0);
        watch_dma("retrig_d0", 8'hD0);
    endtask

    task automatic test_dma_echo();
        dma_write(8'hF2);
        watch_dma("echo_f2", 8'hD2);
    endtask

    // CPU read of 8010 in DRAW (lockout-dependent), then in H_BLANK.
    task automatic test_cpu_vram_gate();
        logic exp_rd;
        logic [15:0] exp;
`ifdef VIDEO_MODE_LOCK_EN
        exp_rd = 1'b0;
        exp_q.push_back({8'h00, 8'hFF});
`else
        exp_rd = 1'b1;
        exp_q.push_back({8'h00, vram_init(16'h0010)});
`endif
        exp_q.push_back({8'h00, vram_init(16'h0010)});
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            bus.ppu_mode = (pass == 0) ? DRAW : H_BLANK;
            bus.cpu_rd   = 1'b1;
            bus.cpu_addr = 16'h8010;
            #1;
            n_checks++;
            if (bus.vram_rd !== ((pass == 0) ? exp_rd : 1'b1)) begin
                n_fail++;
                $display("FAIL vram_gate_rd%0d: got %b expected %b", pass, bus.vram_rd, (pass == 0) ? exp_rd : 1'b1);
            end
            if (pass == 1) begin
                n_checks++;
                if (bus.vram_addr !== 13'h0010) begin
                    n_fail++;
                    $display("FAIL vram_gate_addr: got %h expected 0010", bus.vram_addr);
                end
            end
            @(negedge clk);
            bus.cpu_rd = 1'b0;
            #1;
            exp = exp_q.pop_front();
            n_checks++;
            if (bus.cpu_rdata !== exp[7:0]) begin
                n_fail++;
                $display("FAIL vram_gate_rdata%0d: got %h expected %h", pass, bus.cpu_rdata, exp[7:0]);
            end
        end
        idle_inputs();
    endtask

    // CPU write FE05=33 in SCAN, read back, write in V_BLANK, read back.
    task automatic test_cpu_oam_gate();
        logic [15:0] exp;
        logic exp_wr;
`ifdef VIDEO_MODE_LOCK_EN
        exp_wr = 1'b0;
        exp_q.push_back({8'h05, src_byte(16'hD205)});
`else
        exp_wr = 1'b1;
        exp_q.push_back({8'h05, 8'h33});
`endif
        exp_q.push_back({8'h05, 8'h33});
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            bus.ppu_mode  = (pass == 0) ? SCAN : V_BLANK;
            bus.cpu_wr    = 1'b1;
            bus.cpu_addr  = 16'hFE05;
            bus.cpu_wdata = 8'h33;
            #1;
            n_checks++;
            if (bus.oam_wr !== ((pass == 0) ? exp_wr : 1'b1)) begin
                n_fail++;
                $display("FAIL oam_gate_wr%0d: got %b expected %b", pass, bus.oam_wr, (pass == 0) ? exp_wr : 1'b1);
            end
            if (pass == 1) begin
                n_checks++;
                if ({bus.oam_addr, bus.oam_wdata} !== 16'h0533) begin
                    n_fail++;
                    $display("FAIL oam_gate_addr_data: got %h %h expected 05 33", bus.oam_addr, bus.oam_wdata);
                end
            end
            @(negedge clk);
            bus.cpu_wr   = 1'b0;
            bus.ppu_mode = H_BLANK;
            bus.cpu_rd   = 1'b1;
            @(negedge clk);
            bus.cpu_rd = 1'b0;
            #1;
            exp = exp_q.pop_front();
            n_checks++;
            if (bus.cpu_rdata !== exp[7:0]) begin
                n_fail++;
                $display("FAIL oam_gate_readback%0d: got %h expected %h", pass, bus.cpu_rdata, exp[7:0]);
            end
        end
        idle_inputs();
    endtask

    // Same-cycle CPU and PPU requests to one RAM: PPU wins, CPU denied.
    task automatic test_collision();
        @(negedge clk);
        bus.ppu_mode = H_BLANK;
        bus.ppu_rd   = 1'b1;
        bus.ppu_addr = 16'h8020;
        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = 16'h8030;
        #1;
        n_checks++;
        if (bus.vram_addr !== 13'h0020) begin
            n_fail++;
            $display("FAIL collide_vram_addr: got %h expected 0020", bus.vram_addr);
        end
        @(negedge clk);
        bus.ppu_mode  = V_BLANK;
        bus.ppu_addr  = 16'hFE10;
        bus.cpu_rd    = 1'b0;
        bus.cpu_wr    = 1'b1;
        bus.cpu_addr  = 16'hFE10;
        bus.cpu_wdata = 8'hAA;
        #1;
        n_checks++;
        if ({bus.ppu_rdata, bus.cpu_rdata} !== {vram_init(16'h0020), 8'hFF}) begin
            n_fail++;
            $display("FAIL collide_vram_rdata: got ppu %h cpu %h expected %h ff",
                     bus.ppu_rdata, bus.cpu_rdata, vram_init(16'h0020));
        end
        n_checks++;
        if ({bus.oam_rd, bus.oam_wr, bus.oam_addr} !== {2'b10, 8'h10}) begin
            n_fail++;
            $display("FAIL collide_oam: got rd %b wr %b addr %h expected 1 0 10", bus.oam_rd, bus.oam_wr, bus.oam_addr);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++;
        if (bus.ppu_rdata !== src_byte(16'hD210)) begin
            n_fail++;
            $display("FAIL collide_oam_rdata: got %h expected %h", bus.ppu_rdata, src_byte(16'hD210));
        end
    endtask

    // Range edges: inside ends are served, just-outside addresses read FF.
    task automatic test_address_range();
        logic [15:0] addrs [0:5];
        logic [15:0] exp;
        addrs[0] = 16'h9FFF; addrs[1] = 16'hFE9F; addrs[2] = 16'hFEA0;
        addrs[3] = 16'hFEFF; addrs[4] = 16'h7FFF; addrs[5] = 16'hA000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.ppu_mode = H_BLANK;
            bus.cpu_rd   = 1'b1;
            bus.cpu_addr = addrs[k];
            case (k)
                0:       exp_q.push_back({8'h00, vram_init(16'h1FFF)});
                1:       exp_q.push_back({8'h00, src_byte(16'hD29F)});
                default: exp_q.push_back({8'h00, 8'hFF});
            endcase
            @(negedge clk);
            bus.cpu_rd = 1'b0;
            #1;
            exp = exp_q.pop_front();
            n_checks++;
            if (bus.cpu_rdata !== exp[7:0]) begin
                n_fail++;
                $display("FAIL range_%h: got %h expected %h", addrs[k], bus.cpu_rdata, exp[7:0]);
            end
        end
        idle_inputs();
    endtask

    // PPU OAM read during DMA is suppressed; reset then kills the DMA.
    task automatic test_ppu_blocked_and_reset();
        int wr_n = 0;
        dma_write(8'hC1);
        repeat (5) @(negedge clk);
        bus.ppu_mode = SCAN;
        bus.ppu_rd   = 1'b1;
        bus.ppu_addr = 16'hFE00;
        #1;
        n_checks++;
        if (bus.oam_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL ppu_blocked_rd: got %b expected 0", bus.oam_rd);
        end
        @(negedge clk);
        bus.ppu_rd = 1'b0;
        #1;
        n_checks++;
        if ({bus.ppu_rdata, bus.dma_active} !== {8'hFF, 1'b1}) begin
            n_fail++;
            $display("FAIL ppu_blocked_rdata: got %h active %b expected ff 1", bus.ppu_rdata, bus.dma_active);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.dma_active !== 1'b0 || bus.dma_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_mid_dma: got active %b state %0d expected 0 IDLE", bus.dma_active, bus.dma_state);
        end
        for (int c = 0; c < 350; c++) begin
            @(negedge clk);
            #1;
            if (bus.oam_wr || bus.dma_src_rd) wr_n++;
        end
        n_checks++;
        if (wr_n != 0) begin
            n_fail++;
            $display("FAIL reset_no_more_dma: got %0d dma cycles expected 0", wr_n);
        end
        @(negedge clk);
        bus.ppu_rd   = 1'b1;
        bus.ppu_addr = 16'hFE00;
        @(negedge clk);
        bus.ppu_rd = 1'b0;
        #1;
        n_checks++;
        if (bus.ppu_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL ppu_oam_after_reset: got %h expected 00", bus.ppu_rdata);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_dma_basic();
        test_dma_retrigger();
        test_dma_echo();
        test_cpu_vram_gate();
        test_cpu_oam_gate();
        test_collision();
        test_address_range();
        test_ppu_blocked_and_reset();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_bus_arbiter.md
Name: video_bus_arbiter

Overview:
- Owns the VRAM (8000-9FFF) and OAM (FE00-FE9F) ports and shares them between three requesters: CPU, PPU fetcher, and an internal OAM DMA engine.
- The OAM DMA engine is started by a CPU write to FF46.
- CPU access to VRAM/OAM is gated by PPU mode: H_BLANK=0, V_BLANK=1, SCAN=2, DRAW=3.
- Sits between CPU MMIO decode, the PPU, and the video RAMs.

Parameters:
- OAM_BYTES, 160, number of bytes copied per DMA.
- VRAM_AW, 13, VRAM word address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cpu_addr  in  16  CPU address
- cpu_rd  in  1  CPU read strobe
- cpu_wr  in  1  CPU write strobe
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  read data, valid 1 cycle after cpu_rd
- cpu_dma_blocked  out  1  high while DMA is active; external decode then allows the CPU only FF80-FFFE
- ppu_mode  in  2  current PPU mode
- ppu_rd  in  1  PPU read strobe
- ppu_addr  in  16  PPU address
- ppu_rdata  out  8  PPU read data, 1-cycle latency
- vram_addr  out  VRAM_AW  VRAM address
- vram_rd / vram_wr  out  1  VRAM strobes
- vram_wdata  out  8  VRAM write data
- vram_rdata  in  8  VRAM read data (synchronous, 1 cycle)
- oam_addr  out  8  OAM address
- oam_rd / oam_wr  out  1  OAM strobes
- oam_wdata  out  8  OAM write data
- oam_rdata  in  8  OAM read data (synchronous, 1 cycle)
- dma_src_addr  out  16  DMA source address
- dma_src_rd  out  1  DMA source read strobe
- dma_src_rdata  in  8  DMA source data, 1-cycle latency
- dma_active  out  1  DMA in progress

Behaviour:
- Reset values:
  - All strobes 0; vram_addr, oam_addr, dma_src_addr 0.
  - cpu_rdata and ppu_rdata FF.
  - dma_active and cpu_dma_blocked 0; DMA FSM in IDLE.
- DMA FSM states: IDLE, START, READ, WRITE; 8-bit src_hi register; idx counter 0..OAM_BYTES-1.
- DMA trigger: cpu_wr with cpu_addr==FF46.
  - Latch src_hi = cpu_wdata, or cpu_wdata-8'h20 if cpu_wdata>8'hDF (echo remap).
  - Go to START, from any state.
  - A retrigger mid-transfer restarts at idx=0 with the new source.
- START: one idle cycle; dma_active=1. Then READ.
- READ: dma_src_addr={src_hi,idx}, dma_src_rd=1. Then WRITE.
- WRITE: oam_addr=idx, oam_wdata=dma_src_rdata, oam_wr=1.
  - idx==OAM_BYTES-1: go to IDLE, clear dma_active.
  - Otherwise idx++ and go to READ.
- DMA duration: 1+2*160=321 cycles; dma_active is high in START/READ/WRITE.
- Ownership per cycle:
  - OAM: DMA > PPU (modes SCAN, DRAW) > CPU (modes H_BLANK, V_BLANK).
  - VRAM: PPU (DRAW) > CPU (all other modes).
- PPU access blocked by DMA: PPU OAM reads during DMA are not issued; ppu_rdata=FF.
- CPU access denied: writes dropped; reads return FF next cycle.
- CPU access outside VRAM/OAM ranges (incl. FEA0-FEFF): ignored; cpu_rdata=FF.
- VRAM address = cpu/ppu_addr-16'h8000, truncated to VRAM_AW bits. OAM address = addr[7:0].
- Read-data return: a registered 2-bit source tag per requester (NONE/VRAM/OAM) selects the rdata mux next cycle.
- Simultaneous CPU and PPU request to the same RAM in a mode where the CPU is allowed: PPU wins; CPU denied.
- Reset mid-DMA: FSM to IDLE; no further OAM writes.

Optional Feature:
- Macro: VIDEO_MODE_LOCK_EN.
- Defined: mode-based CPU lockout as above.
- Undefined: the CPU may access VRAM/OAM in any mode when the PPU is not requesting that RAM in the same cycle. Collisions are still PPU-wins and DMA still owns OAM.

Decomposition:
- Shared package video_pkg:
  - ppu_mode_t enum (H_BLANK, V_BLANK, SCAN, DRAW)
  - dma_state_t
  - constants VRAM_BASE=16'h8000, VRAM_END=16'h9FFF, OAM_BASE=16'hFE00, OAM_END=16'hFE9F, DMA_REG=16'hFF46, ECHO_LIMIT=8'hDF
- Sub-module oam_dma_engine: FSM, idx, src_hi, dma_src_*, and DMA OAM write outputs.
- video_bus_arbiter: grant logic and read-return muxing.

Test Plan:
- Write FF46=8'hC1; source returns byte i at C100+i -> dma_active high for 321 cycles; OAM[i]=i for i=0..159; last oam_wr at idx 9F.
- Write FF46=8'hC1, then FF46=8'hD0 at cycle 50 -> transfer restarts at idx 0 from D000; total active time 321 cycles after the second write.
- Write FF46=8'hF2 -> dma_src_addr sequence starts at D200 (echo remap).
- ppu_mode=DRAW, CPU reads 8010 -> no vram_rd from CPU; cpu_rdata=FF. ppu_mode=H_BLANK, same read -> vram_addr=0010 and cpu_rdata=vram_rdata.
- ppu_mode=SCAN, CPU writes FE05=8'h33 -> no oam_wr; then in V_BLANK the same write -> oam_addr=05, oam_wdata=33.
- ppu_mode=SCAN, DMA active, PPU reads FE00 -> ppu_rdata=FF; assert rst during DMA -> dma_active=0 next cycle, no further oam_wr.
